// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: shared states, constants and lane helpers for the data memory bridge
package dmem_bridge_pkg;
  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_REQ  = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_e;
  localparam logic [7:0] DMEM_TIMEOUT_BYTE = 8'hFF;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  function automatic logic [1:0] first_lane(input logic [3:0] sel);
    return sel[0] ? 2'd0 : sel[1] ? 2'd1 : sel[2] ? 2'd2 : 2'd3;
  endfunction
  function automatic logic [7:0] byte_at(input logic [31:0] w, input logic [1:0] l);
    return w[{l, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/dmem_lane_next.sv
// dmem_lane_next: next selected byte lane above the current one, plus a last-lane flag
module dmem_lane_next
  import dmem_bridge_pkg::*;
(
  input  logic [3:0] sel,
  input  logic [1:0] lane,
  output logic [1:0] nxt,
  output logic       last
);
  logic [3:0] above;
  // keep only selected lanes strictly above the current one
  always_comb begin
    above = sel & ~((4'd2 << lane) - 4'd1);
    nxt   = first_lane(above);
    last  = above == 4'd0;
  end
endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: serves MEM-stage requests one byte lane at a time over an ext req/ack port
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int ADDR_W  = 17,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              stallreq_o,
  output logic              err_o,
  output logic              ext_req_o,
  output logic              ext_we_o,
  output logic [ADDR_W-1:0] ext_addr_o,
  output logic [7:0]        ext_wdata_o,
  input  logic [7:0]        ext_rdata_i,
  input  logic              ext_ack_i
);
  localparam int CW = $clog2(TIMEOUT + 1) + 1;
  dmem_state_e       state, state_n;
  logic              we_q, err_q, start, tmo, acc, last;
  logic [ADDR_W-1:2] addr_q;
  logic [3:0]        sel_q;
  logic [31:0]       data_q, buf_q;
  logic [1:0]        lane, nxt, fl;
  logic [CW-1:0]     cnt;
  logic              unused_addr;
  assign unused_addr = ^{mem_addr_i[31:ADDR_W], mem_addr_i[1:0]};
  assign fl = first_lane(mem_sel_i);
  dmem_lane_next u_next (
    .sel  (sel_q),
    .lane (lane),
    .nxt  (nxt),
    .last (last)
  );
  // state register
  always_ff @(posedge clk) state <= rst ? DMEM_IDLE : state_n;
  // next state, stall, timeout detection and MEM-side outputs
  always_comb begin
    start      = state == DMEM_IDLE && mem_ce_i && mem_sel_i != 4'd0;
    tmo        = TIMEOUT != 0 && state == DMEM_REQ && !ext_ack_i && cnt == CW'(TIMEOUT - 1);
    acc        = state == DMEM_REQ && ext_req_o && (ext_ack_i || tmo);
    state_n    = start ? DMEM_REQ : (acc && last) ? DMEM_DONE : state == DMEM_DONE ? DMEM_IDLE : state;
    stallreq_o = start || state == DMEM_REQ;
    mem_data_o = state == DMEM_DONE ? buf_q : ZERO_WORD;
    err_o      = state == DMEM_DONE && err_q;
  end
  // request latch, per-lane external transaction and read capture
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      sel_q       <= 4'd0;
      data_q      <= ZERO_WORD;
      buf_q       <= ZERO_WORD;
      lane        <= 2'd0;
      cnt         <= '0;
      err_q       <= 1'b0;
      ext_req_o   <= 1'b0;
      ext_we_o    <= 1'b0;
      ext_addr_o  <= '0;
      ext_wdata_o <= 8'd0;
    end else if (start) begin
      we_q        <= mem_we_i;
      addr_q      <= mem_addr_i[ADDR_W-1:2];
      sel_q       <= mem_sel_i;
      data_q      <= mem_data_i;
      buf_q       <= ZERO_WORD;
      lane        <= fl;
      cnt         <= '0;
      ext_req_o   <= 1'b1;
      ext_we_o    <= mem_we_i;
      ext_addr_o  <= {mem_addr_i[ADDR_W-1:2], fl};
      ext_wdata_o <= byte_at(mem_data_i, fl);
    end else if (acc) begin
      if (!we_q) buf_q[{lane, 3'b000} +: 8] <= ext_ack_i ? ext_rdata_i : DMEM_TIMEOUT_BYTE;
      if (tmo) err_q <= 1'b1;
      cnt <= '0;
      if (last) begin
        ext_req_o <= 1'b0;
        ext_we_o  <= 1'b0;
      end else begin
        lane        <= nxt;
        ext_addr_o  <= {addr_q, nxt};
        ext_wdata_o <= byte_at(data_q, nxt);
      end
    end else if (state == DMEM_REQ) begin
      cnt <= cnt + 1'b1;
    end else if (state == DMEM_DONE) begin
      err_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed checks of the byte-lane data memory bridge
module tb_dmem_bridge;
  logic        clk = 1'b0;
  logic        rst, mem_ce_i, mem_we_i, ext_ack_i;
  logic [31:0] mem_addr_i, mem_data_i, mem_data_o;
  logic [3:0]  mem_sel_i;
  logic [7:0]  ext_rdata_i, ext_wdata_o;
  logic        stallreq_o, err_o, ext_req_o, ext_we_o;
  logic [16:0] ext_addr_o;
  int          passed = 0, total = 0, stalls;
  logic [7:0]  rd_bytes [4];

  dmem_bridge #(.ADDR_W(17), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i),
    .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i),
    .mem_data_o(mem_data_o), .stallreq_o(stallreq_o), .err_o(err_o),
    .ext_req_o(ext_req_o), .ext_we_o(ext_we_o), .ext_addr_o(ext_addr_o),
    .ext_wdata_o(ext_wdata_o), .ext_rdata_i(ext_rdata_i), .ext_ack_i(ext_ack_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] data);
    mem_ce_i = 1'b1;
    mem_we_i = we;
    mem_addr_i = addr;
    mem_sel_i = sel;
    mem_data_i = data;
  endtask

  initial begin
    rst = 1'b1; mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0;
    mem_data_i = '0; ext_rdata_i = '0; ext_ack_i = 1'b0;
    cyc(); cyc();
    chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
    chk("rst_req", {31'd0, ext_req_o}, 32'd0);
    chk("rst_we", {31'd0, ext_we_o}, 32'd0);
    chk("rst_addr", {15'd0, ext_addr_o}, 32'd0);
    chk("rst_wdata", {24'd0, ext_wdata_o}, 32'd0);
    chk("rst_rdata", mem_data_o, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    rst = 1'b0;
    cyc();
    // LW 0x100, zero-wait ack
    rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;
    req(1'b0, 32'h100, 4'b1111, 32'h0);
    ext_ack_i = 1'b1;
    #1;
    stalls = 0;
    chk("lw_idle_stall", {31'd0, stallreq_o}, 32'd1);
    chk("lw_idle_noreq", {31'd0, ext_req_o}, 32'd0);
    if (stallreq_o) stalls++;
    for (int k = 0; k < 4; k++) begin
      cyc();
      ext_rdata_i = rd_bytes[k];
      if (stallreq_o) stalls++;
      chk($sformatf("lw_req%0d", k), {31'd0, ext_req_o}, 32'd1);
      chk($sformatf("lw_addr%0d", k), {15'd0, ext_addr_o}, 32'h100 + k);
      chk($sformatf("lw_we%0d", k), {31'd0, ext_we_o}, 32'd0);
      chk($sformatf("lw_mdata%0d", k), mem_data_o, 32'd0);
    end
    cyc();
    chk("lw_stall_cycles", stalls, 32'd5);
    chk("lw_done_stall", {31'd0, stallreq_o}, 32'd0);
    chk("lw_done_data", mem_data_o, 32'h44332211);
    chk("lw_done_noreq", {31'd0, ext_req_o}, 32'd0);
    chk("lw_done_err", {31'd0, err_o}, 32'd0);
    mem_ce_i = 1'b0; ext_ack_i = 1'b0;
    cyc();
    chk("lw_idle_data", mem_data_o, 32'd0);
    chk("lw_idle_stall2", {31'd0, stallreq_o}, 32'd0);
    // SB 0x203, ack on the fourth request cycle
    req(1'b1, 32'h203, 4'b1000, 32'hA5A5A5A5);
    #1;
    stalls = stallreq_o ? 1 : 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      ext_ack_i = (k == 3);
      if (stallreq_o) stalls++;
      chk($sformatf("sb_req%0d", k), {31'd0, ext_req_o}, 32'd1);
      chk($sformatf("sb_we%0d", k), {31'd0, ext_we_o}, 32'd1);
      chk($sformatf("sb_addr%0d", k), {15'd0, ext_addr_o}, 32'h203);
      chk($sformatf("sb_wdata%0d", k), {24'd0, ext_wdata_o}, 32'hA5);
    end
    cyc();
    ext_ack_i = 1'b0;
    chk("sb_stall_cycles", stalls, 32'd5);
    chk("sb_done_stall", {31'd0, stallreq_o}, 32'd0);
    chk("sb_done_data", mem_data_o, 32'd0);
    chk("sb_done_err", {31'd0, err_o}, 32'd0);
    chk("sb_done_noreq", {31'd0, ext_req_o}, 32'd0);
    mem_ce_i = 1'b0;
    cyc();
    // LH upper half at 0x302
    req(1'b0, 32'h302, 4'b1100, 32'h0);
    ext_ack_i = 1'b1;
    cyc();
    ext_rdata_i = 8'h80;
    chk("lh_addr0", {15'd0, ext_addr_o}, 32'h302);
    cyc();
    ext_rdata_i = 8'h7F;
    chk("lh_addr1", {15'd0, ext_addr_o}, 32'h303);
    chk("lh_req1", {31'd0, ext_req_o}, 32'd1);
    cyc();
    chk("lh_done_data", mem_data_o, 32'h7F800000);
    chk("lh_done_noreq", {31'd0, ext_req_o}, 32'd0);
    mem_ce_i = 1'b0; ext_ack_i = 1'b0;
    cyc();
    // read lane 0 with no ack: timeout after 4 request cycles
    req(1'b0, 32'h400, 4'b0001, 32'h0);
    ext_rdata_i = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("to_req%0d", k), {31'd0, ext_req_o}, 32'd1);
      chk($sformatf("to_stall%0d", k), {31'd0, stallreq_o}, 32'd1);
      chk($sformatf("to_err%0d", k), {31'd0, err_o}, 32'd0);
    end
    cyc();
    chk("to_done_data", mem_data_o, 32'h000000FF);
    chk("to_done_err", {31'd0, err_o}, 32'd1);
    chk("to_done_stall", {31'd0, stallreq_o}, 32'd0);
    mem_ce_i = 1'b0;
    cyc();
    chk("to_err_pulse", {31'd0, err_o}, 32'd0);
    // word write interrupted by reset on its second lane
    req(1'b1, 32'h500, 4'b1111, 32'hDDCCBBAA);
    ext_ack_i = 1'b1;
    cyc();
    chk("rw_addr0", {15'd0, ext_addr_o}, 32'h500);
    chk("rw_wdata0", {24'd0, ext_wdata_o}, 32'hAA);
    cyc();
    chk("rw_addr1", {15'd0, ext_addr_o}, 32'h501);
    chk("rw_wdata1", {24'd0, ext_wdata_o}, 32'hBB);
    ext_ack_i = 1'b0; rst = 1'b1; mem_ce_i = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    chk("rw_rst_req", {31'd0, ext_req_o}, 32'd0);
    chk("rw_rst_stall", {31'd0, stallreq_o}, 32'd0);
    ext_ack_i = 1'b1;
    cyc();
    chk("rw_late_ack_req", {31'd0, ext_req_o}, 32'd0);
    chk("rw_late_ack_stall", {31'd0, stallreq_o}, 32'd0);
    chk("rw_late_ack_data", mem_data_o, 32'd0);
    ext_ack_i = 1'b0;
    // ce with no lanes selected
    req(1'b0, 32'h600, 4'b0000, 32'h0);
    #1;
    chk("sel0_stall", {31'd0, stallreq_o}, 32'd0);
    cyc();
    chk("sel0_req", {31'd0, ext_req_o}, 32'd0);
    chk("sel0_data", mem_data_o, 32'd0);
    chk("sel0_stall2", {31'd0, stallreq_o}, 32'd0);
    mem_ce_i = 1'b0;
    cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Responder for the MEM-stage data memory request: takes the combinational request (ce, we, addr, byte sel, write data) and returns read data.
- Serves the request against an external byte-wide memory through a req/ack handshake, one byte lane per transaction.
- Holds the pipeline with stallreq_o until all selected lanes are done.
- Sits between the MEM stage and the board-level byte memory/UART RAM; stallreq_o feeds the pipeline control block.

Parameters:
- ADDR_W, 17, external byte-address width.
- TIMEOUT, 255, max cycles to wait for ext_ack_i per lane; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high (`RstEnable)
- mem_ce_i  in  1  request valid (`ChipEnable)
- mem_we_i  in  1  1 = write, 0 = read
- mem_addr_i  in  32  byte address; bits [1:0] ignored, lanes come from sel
- mem_sel_i  in  4  byte-lane select; bit k = byte [8k+7:8k]
- mem_data_i  in  32  write data, lane-replicated by the requester
- mem_data_o  out  32  read data back to the MEM stage
- stallreq_o  out  1  pipeline stall request
- err_o  out  1  one-cycle pulse: at least one lane timed out
- ext_req_o  out  1  external transaction request
- ext_we_o  out  1  external write strobe qualifier
- ext_addr_o  out  ADDR_W  external byte address
- ext_wdata_o  out  8  external write byte
- ext_rdata_i  in  8  external read byte, valid with ext_ack_i
- ext_ack_i  in  1  transaction complete

Behaviour:
- Reset: synchronous, active-high; single clock clk.
  - State goes to IDLE.
  - All outputs go to 0: ext_req_o, ext_we_o, ext_addr_o, ext_wdata_o, mem_data_o, stallreq_o, err_o.
  - Capture buffer, lane index, timeout counter and error flag are cleared.
  - A reset mid-transaction abandons it; ext_req_o is low from the next cycle.
- States: IDLE, REQ, DONE.
- IDLE:
  - stallreq_o = mem_ce_i & (mem_sel_i != 0), combinational in the same cycle; the MEM stage is combinational and must freeze now.
  - On that condition: latch we, addr, sel and data; clear buffer; select the lowest set sel bit as lane; go to REQ.
  - ce with sel = 0: no stall, no external access, mem_data_o = 0.
  - ext_ack_i in IDLE or DONE is ignored.
- REQ (stallreq_o = 1):
  - ext_req_o = 1, ext_we_o = latched we.
  - ext_addr_o = {latched addr[ADDR_W-1:2], lane[1:0]}.
  - ext_wdata_o = latched data[8*lane+7:8*lane].
  - All of these are registered and held stable until ack.
  - An ack is accepted on any cycle where ext_req_o = 1 and ext_ack_i = 1.
  - On read ack: buffer[8*lane+7:8*lane] <= ext_rdata_i.
  - After ack, advance lane to the next set sel bit in ascending order.
  - If no set bit remains: ext_req_o goes low next cycle and the state moves to DONE.
  - Otherwise the next lane's request appears the next cycle. ext_req_o may stay high across lanes; address/data change together.
  - Timeout counter resets per lane. When TIMEOUT != 0 and the count reaches TIMEOUT with no ack:
    - the lane is aborted and treated as acked;
    - read byte = 8'hFF;
    - the error flag is set.
- DONE (one cycle):
  - stallreq_o = 0.
  - mem_data_o = buffer; unselected lanes read 0; writes return 0.
  - err_o = error flag, then the flag is cleared.
  - Next state is IDLE. The pipeline advances on this edge, so the same request is not re-served.
- mem_data_o = 0 in IDLE and REQ.
- Latency, zero-wait ack, n selected lanes: stallreq_o high for n+1 cycles (IDLE entry + n REQ cycles), then one DONE cycle. Example: word read = 5 stall cycles + DONE.
- Lane order is always ascending, so there is exactly one outstanding external transaction at a time.

Decomposition:
- Shared defines file: state encodings `DMEM_IDLE/`DMEM_REQ/`DMEM_DONE (2 bits) and `DmemTimeoutByte 8'hFF.
- Reuse the existing `RstEnable, `ChipEnable, `WriteEnable, `ZeroWord and `RegBus from the shared defines.
- One sub-module, dmem_lane_next: combinational; given sel[3:0] and current lane, returns the next set lane plus a "last" flag.

Test Plan:
- LW, addr 0x100, sel 1111, ext memory bytes 11,22,33,44, zero-wait ack -> ext_addr 0x100..0x103 in order; stallreq_o high 5 cycles; DONE mem_data_o = 0x44332211.
- SB, addr 0x203, sel 1000, data 0xA5A5A5A5, ack after 3 cycles -> single ext write, ext_addr 0x203, wdata 0xA5; stall 5 cycles; DONE mem_data_o = 0.
- LH, sel 1100, bytes 0x80,0x7F at 0x302/0x303 -> ext reads at 0x302,0x303 only; mem_data_o = 0x7F800000 (sign extension stays in MEM stage).
- Read sel 0001 with TIMEOUT=4, ack never asserted -> lane aborted after 4 wait cycles; DONE mem_data_o = 0x000000FF; err_o pulses 1 cycle.
- rst asserted during the 2nd lane of a word write -> ext_req_o low next cycle; state IDLE; stallreq_o 0 with ce low; later ack ignored.
- ce with sel 0000 -> no stall; no ext_req_o; mem_data_o = 0.
